ori_hist_acc: RTL

Dominant-orientation histogram accumulator for the keypoint orientation-assignment stage. It sits directly downstream of the 5-bit direction lookup ROMs. Each accepted sample adds its gradient magnitude into one of 32 orientation bins selected by the ROM's direction code. When a window ends, the block scans the histogram and emits the peak bin index and peak value to the descriptor stage.

---
 rtl/ori_hist_acc.sv | 130 +++++++++++++
 1 files changed

// File: rtl/ori_hist_acc.sv
// Orientation histogram accumulator: sums gradient magnitudes into 32 direction
// bins per keypoint window, then scans for the peak bin and presents it downstream.
module ori_hist_acc #(
    parameter int MAG_W = 8,
    parameter int ACC_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [4:0]       s_dir,
    input  logic [MAG_W-1:0] s_mag,
    input  logic             s_last,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [4:0]       m_bin,
    output logic [ACC_W-1:0] m_peak,
    output logic [15:0]      m_count
);

    typedef enum logic [1:0] {ST_ACCUM, ST_SCAN, ST_DONE} state_t;

    state_t           state_q, state_d;
    logic [ACC_W-1:0] bin_q [32];
    logic [ACC_W-1:0] bin_d [32];
    logic [15:0]      count_q, count_d;
    logic [4:0]       scan_idx_q, scan_idx_d;
    logic [ACC_W-1:0] max_q, max_d;
    logic [4:0]       max_bin_q, max_bin_d;
    logic             s_ready_q, s_ready_d;
    logic             m_valid_q, m_valid_d;
    logic             accept;
    logic             handshake;
    logic [ACC_W-1:0] scan_val;

    function automatic logic [ACC_W-1:0] sat_acc(input logic [ACC_W-1:0] acc,
                                                 input logic [MAG_W-1:0] mag);
        logic [ACC_W:0] sum;
        sum = {1'b0, acc} + {{(ACC_W + 1 - MAG_W){1'b0}}, mag};
        return sum[ACC_W] ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
    endfunction

    function automatic logic [15:0] sat_cnt(input logic [15:0] cnt);
        return (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
    endfunction

    always_comb begin
        state_d    = state_q;
        bin_d      = bin_q;
        count_d    = count_q;
        scan_idx_d = scan_idx_q;
        max_d      = max_q;
        max_bin_d  = max_bin_q;
        accept     = s_valid && s_ready_q;
        handshake  = m_valid_q && m_ready;
        scan_val   = bin_q[scan_idx_q];

        case (state_q)
            ST_ACCUM: begin
                // Same-edge read-modify-write keeps back-to-back same-bin samples hazard free
                if (accept) begin
                    bin_d[s_dir] = sat_acc(bin_q[s_dir], s_mag);
                    count_d      = sat_cnt(count_q);
                    if (s_last) begin
                        state_d    = ST_SCAN;
                        scan_idx_d = 5'd0;
                    end
                end
            end
            ST_SCAN: begin
                // Strictly-greater replacement makes ties resolve to the lowest index
                if (scan_idx_q == 5'd0) begin
                    max_d     = scan_val;
                    max_bin_d = 5'd0;
                end else if (scan_val > max_q) begin
                    max_d     = scan_val;
                    max_bin_d = scan_idx_q;
                end
                scan_idx_d = scan_idx_q + 5'd1;
                if (scan_idx_q == 5'd31) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (handshake) begin
                    for (int i = 0; i < 32; i++) begin
                        bin_d[i] = '0;
                    end
                    count_d = 16'd0;
                    state_d = ST_ACCUM;
                end
            end
            default: state_d = ST_ACCUM;
        endcase

        s_ready_d = (state_d == ST_ACCUM);
        m_valid_d = (state_q == ST_DONE) && !handshake;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_ACCUM;
            for (int i = 0; i < 32; i++) begin
                bin_q[i] <= '0;
            end
            count_q    <= 16'd0;
            scan_idx_q <= 5'd0;
            max_q      <= '0;
            max_bin_q  <= 5'd0;
            s_ready_q  <= 1'b1;
            m_valid_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            bin_q      <= bin_d;
            count_q    <= count_d;
            scan_idx_q <= scan_idx_d;
            max_q      <= max_d;
            max_bin_q  <= max_bin_d;
            s_ready_q  <= s_ready_d;
            m_valid_q  <= m_valid_d;
        end
    end

    assign s_ready = s_ready_q;
    assign m_valid = m_valid_q;
    assign m_bin   = max_bin_q;
    assign m_peak  = max_q;
    assign m_count = count_q;

endmodule
